// File: rtl/calc_seq_ctrl.sv
// Multi-pass sequencer that time-shares an external W-bit adder to run
// 2W-bit ADD/SUB and WxW unsigned MUL, capturing sum/carry once per cycle.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_start; adder inputs driven to 0
// LO     | low-word pass (a_lo + b_lo, or a_lo + ~b_lo with local +1)
// HI     | high-word pass (a_hi + b_hi, or a_hi + ~b_hi)
// CORR   | propagate low-word carry into the high word (res_hi + 1)
// MUL    | one shift-add pass per cycle, W passes in total
// DONE   | o_done pulse; result and flags valid, back to IDLE next edge
module calc_seq_ctrl #(
    parameter int W = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_start,
    input  logic [1:0]     i_op,
    input  logic [2*W-1:0] i_a,
    input  logic [2*W-1:0] i_b,
    output logic [W-1:0]   o_add_a,
    output logic [W-1:0]   o_add_b,
    output logic           o_add_mode,
    input  logic [W-1:0]   i_add_sum,
    input  logic           i_add_carry,
    output logic [2*W-1:0] o_result,
    output logic           o_carry,
    output logic           o_err,
    output logic           o_busy,
    output logic           o_done
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_CORR,
        S_MUL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   res_lo_q, res_lo_d;
    logic [W-1:0]   res_hi_q, res_hi_d;
    logic           carry_lo_q, carry_lo_d;
    logic           carry_hi_q, carry_hi_d;
    logic           err_q, err_d;
    logic [W-1:0]   acc_hi_q, acc_hi_d;
    logic [W-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   add_a, add_b;
    logic [W-1:0]   lo_inc;
    logic [2*W:0]   mul_shift;
    logic           is_sub;

    assign is_sub    = (op_q == OP_SUB);
    assign lo_inc    = i_add_sum + {{(W-1){1'b0}}, 1'b1};
    assign mul_shift = {i_add_carry, i_add_sum, acc_lo_q} >> 1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            carry_lo_q <= 1'b0;
            carry_hi_q <= 1'b0;
            err_q      <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            carry_lo_q <= carry_lo_d;
            carry_hi_q <= carry_hi_d;
            err_q      <= err_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        carry_lo_d = carry_lo_q;
        carry_hi_d = carry_hi_q;
        err_d      = err_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        cnt_d      = cnt_q;
        add_a      = '0;
        add_b      = '0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d        = i_a;
                    b_d        = i_b;
                    op_d       = i_op;
                    res_lo_d   = '0;
                    res_hi_d   = '0;
                    carry_lo_d = 1'b0;
                    carry_hi_d = 1'b0;
                    err_d      = 1'b0;
                    acc_hi_d   = '0;
                    acc_lo_d   = i_b[W-1:0];
                    cnt_d      = '0;
                    case (i_op)
                        OP_ADD, OP_SUB: state_d = S_LO;
                        OP_MUL:         state_d = S_MUL;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_LO: begin
                add_a = a_q[W-1:0];
                add_b = is_sub ? ~b_q[W-1:0] : b_q[W-1:0];
                // SUB folds its +1 here: a sum of all-ones becomes a carry
                if (is_sub) begin
                    res_lo_d   = lo_inc;
                    carry_lo_d = (&i_add_sum) | i_add_carry;
                end else begin
                    res_lo_d   = i_add_sum;
                    carry_lo_d = i_add_carry;
                end
                state_d = S_HI;
            end
            S_HI: begin
                add_a      = a_q[2*W-1:W];
                add_b      = is_sub ? ~b_q[2*W-1:W] : b_q[2*W-1:W];
                res_hi_d   = i_add_sum;
                carry_hi_d = i_add_carry;
                state_d    = carry_lo_q ? S_CORR : S_DONE;
            end
            S_CORR: begin
                add_a      = res_hi_q;
                add_b      = {{(W-1){1'b0}}, 1'b1};
                res_hi_d   = i_add_sum;
                carry_hi_d = carry_hi_q | i_add_carry;
                state_d    = S_DONE;
            end
            S_MUL: begin
                add_a    = acc_hi_q;
                add_b    = acc_lo_q[0] ? a_q[W-1:0] : '0;
                acc_hi_d = mul_shift[2*W-1:W];
                acc_lo_d = mul_shift[W-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_hi_d = mul_shift[2*W-1:W];
                    res_lo_d = mul_shift[W-1:0];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_add_a    = add_a;
    assign o_add_b    = add_b;
    assign o_add_mode = 1'b0;
    assign o_result   = {res_hi_q, res_lo_q};
    assign o_carry    = carry_hi_q;
    assign o_err      = err_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);

endmodule
